// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath.
package mips_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_R_EXEC,
        ST_R_WB,
        ST_I_EXEC,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } ctrl_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM driving datapath enables and mux selects.
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int OPC_W = OPCODE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             stall,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op
);

    ctrl_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!stall) begin
            case (state)
                ST_INIT:   state_nxt = ST_FETCH;
                ST_FETCH:  state_nxt = ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:            state_nxt = ST_MEM_ADDR;
                        OP_RTYPE:                state_nxt = ST_R_EXEC;
                        OP_ADDI, OP_ANDI, OP_ORI: state_nxt = ST_I_EXEC;
                        OP_BEQ, OP_BNE:          state_nxt = ST_BRANCH;
                        OP_J:                    state_nxt = ST_JUMP;
                        default:                 state_nxt = ST_HALT;
                    endcase
                end
                ST_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ:  state_nxt = ST_MEM_WB;
                ST_MEM_WB:    state_nxt = ST_FETCH;
                ST_MEM_WRITE: state_nxt = ST_FETCH;
                ST_R_EXEC:    state_nxt = ST_R_WB;
                ST_R_WB:      state_nxt = ST_FETCH;
                ST_I_EXEC:    state_nxt = ST_I_WB;
                ST_I_WB:      state_nxt = ST_FETCH;
                ST_BRANCH:    state_nxt = ST_FETCH;
                ST_JUMP:      state_nxt = ST_FETCH;
                ST_HALT:      state_nxt = ST_HALT;
                default:      state_nxt = ST_INIT;
            endcase
        end
    end

    // Architectural-state strobes are masked while stalled so a held state
    // never commits twice; read strobe and selects keep their state values.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = !stall;
                alu_src_b = SRCB_FOUR;
                pc_write  = !stall;
            end
            ST_DECODE: alu_src_b = SRCB_IMMSH;
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = !stall;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = !stall;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = !stall;
                reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
            end
            ST_I_WB: reg_write = !stall;
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = !stall;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = (opcode == OP_BNE);
            end
            ST_JUMP: begin
                pc_write  = !stall;
                pc_source = PCSRC_JUMP;
            end
            ST_HALT: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed, table-driven bench for the multicycle MIPS controller.
module tb_mips_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       stall = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int checks = 0;
    int failures = 0;

    mips_ctrl_fsm #(.OPC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                   illegal_op};

    localparam logic [17:0] E_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_FETCH   = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] E_FETCH_S = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] E_MADDR   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] E_MREAD   = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_MWB     = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] E_MWB_S   = 18'b0_0_0_0_0_0_0_1_0_0_0_00_00_00_0;
    localparam logic [17:0] E_MWRITE  = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_MWR_S   = 18'b0_0_0_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_REXEC   = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] E_RWB     = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] E_RWB_S   = 18'b0_0_0_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [17:0] E_IEXEC   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [17:0] E_IWB     = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [17:0] E_BEQ     = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] E_BNE     = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] E_HALT    = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        stl;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [5:0] op, input logic stl,
                       input logic [17:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.stl = stl; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [17:0] exp);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end
    endtask

    initial begin
        // lw: 5 cycles
        add("lw_fetch", 6'h23, 0, E_FETCH);   add("lw_decode", 6'h23, 0, E_DECODE);
        add("lw_maddr", 6'h23, 0, E_MADDR);   add("lw_mread", 6'h23, 0, E_MREAD);
        add("lw_mwb", 6'h23, 0, E_MWB);
        // sw with 3-cycle stall in MEM_WRITE
        add("sw_fetch", 6'h2B, 0, E_FETCH);   add("sw_decode", 6'h2B, 0, E_DECODE);
        add("sw_maddr", 6'h2B, 0, E_MADDR);
        add("sw_stall0", 6'h2B, 1, E_MWR_S);  add("sw_stall1", 6'h2B, 1, E_MWR_S);
        add("sw_stall2", 6'h2B, 1, E_MWR_S);  add("sw_mwrite", 6'h2B, 0, E_MWRITE);
        // R-type: 4 cycles
        add("r_fetch", 6'h00, 0, E_FETCH);    add("r_decode", 6'h00, 0, E_DECODE);
        add("r_exec", 6'h00, 0, E_REXEC);     add("r_wb", 6'h00, 0, E_RWB);
        // addi / andi / ori
        add("addi_fetch", 6'h08, 0, E_FETCH); add("addi_decode", 6'h08, 0, E_DECODE);
        add("addi_exec", 6'h08, 0, E_IEXEC);  add("addi_wb", 6'h08, 0, E_IWB);
        add("andi_fetch", 6'h0C, 0, E_FETCH); add("andi_decode", 6'h0C, 0, E_DECODE);
        add("andi_exec", 6'h0C, 0, E_IEXEC);  add("andi_wb", 6'h0C, 0, E_IWB);
        add("ori_fetch", 6'h0D, 0, E_FETCH);  add("ori_decode", 6'h0D, 0, E_DECODE);
        add("ori_exec", 6'h0D, 0, E_IEXEC);   add("ori_wb", 6'h0D, 0, E_IWB);
        // branches and jump: 3 cycles
        add("beq_fetch", 6'h04, 0, E_FETCH);  add("beq_decode", 6'h04, 0, E_DECODE);
        add("beq_branch", 6'h04, 0, E_BEQ);
        add("bne_fetch", 6'h05, 0, E_FETCH);  add("bne_decode", 6'h05, 0, E_DECODE);
        add("bne_branch", 6'h05, 0, E_BNE);
        add("j_fetch", 6'h02, 0, E_FETCH);    add("j_decode", 6'h02, 0, E_DECODE);
        add("j_jump", 6'h02, 0, E_JUMP);
        // stalls in FETCH, R_EXEC, R_WB and MEM_WB
        add("fs_fetch_stall", 6'h00, 1, E_FETCH_S); add("fs_fetch", 6'h00, 0, E_FETCH);
        add("fs_decode", 6'h00, 0, E_DECODE); add("fs_rexec_stall", 6'h00, 1, E_REXEC);
        add("fs_rexec", 6'h00, 0, E_REXEC);   add("fs_rwb_stall", 6'h00, 1, E_RWB_S);
        add("fs_rwb", 6'h00, 0, E_RWB);
        add("ls_fetch", 6'h23, 0, E_FETCH);   add("ls_decode", 6'h23, 0, E_DECODE);
        add("ls_maddr", 6'h23, 0, E_MADDR);   add("ls_mread_stall", 6'h23, 1, E_MREAD);
        add("ls_mread", 6'h23, 0, E_MREAD);   add("ls_mwb_stall", 6'h23, 1, E_MWB_S);
        add("ls_mwb", 6'h23, 0, E_MWB);
        // illegal opcode: HALT is sticky whatever the inputs do
        add("ill_fetch", 6'h3F, 0, E_FETCH);  add("ill_decode", 6'h3F, 0, E_DECODE);
        for (int i = 0; i < 10; i++)
            add("ill_halt", (i < 5) ? 6'h3F : 6'h00, (i % 3) == 1, E_HALT);

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_low", E_ZERO);
        rst_n = 1'b1;
        #1 check("init_after_release", E_ZERO);

        foreach (vecs[k]) begin
            @(negedge clk);
            opcode = vecs[k].op;
            stall  = vecs[k].stl;
            #1 check(vecs[k].name, vecs[k].exp);
        end

        // async reset out of HALT clears illegal_op
        @(negedge clk);
        stall = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("halt_async_reset", E_ZERO);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("halt_rst_init", E_ZERO);
        @(negedge clk) #1 check("halt_rst_fetch", E_FETCH);

        // async reset mid-R_EXEC, held two cycles
        @(negedge clk) opcode = 6'h00;
        #1 check("mr_decode", E_DECODE);
        @(negedge clk) #1 check("mr_rexec", E_REXEC);
        #1 rst_n = 1'b0;
        #1 check("mr_async_zero", E_ZERO);
        repeat (2) @(posedge clk);
        #1 check("mr_held_zero", E_ZERO);
        @(negedge clk) rst_n = 1'b1;
        #1 check("mr_init", E_ZERO);
        @(negedge clk) #1 check("mr_fetch", E_FETCH);
        @(negedge clk) #1 check("mr_decode2", E_DECODE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multicycle MIPS main controller: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and writeback cycles. It decodes the instruction-register opcode and drives the datapath enables plus the select lines of the 4:1 and 2:1 datapath multiplexers, including ALU operand B (`alu_src_b`) and next-PC source (`pc_source`). It sits directly upstream of those muxes, register file, memory port and ALU control.

## Interface
- `OPC_W`, 6: opcode width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  OPC_W  IR[31:26], valid from the DECODE cycle onward.
- `stall`  in  1  memory not ready; freezes the FSM.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if branch condition holds.
- `branch_ne`  out  1  condition sense; 0 = beq (zero), 1 = bne (!zero).
- `i_or_d`  out  1  memory address mux; 0 = PC, 1 = ALU out.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  writeback mux; 0 = ALU out, 1 = MDR.
- `reg_dst`  out  1  dest register; 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_op`  out  2  00 add, 01 sub, 10 decode funct, 11 decode opcode (I-type).
- `pc_source`  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target, 11 unused (never driven).
- `illegal_op`  out  1  sticky; high in HALT.

## Operation
- States: INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, HALT.
- INIT: all outputs 0; next FETCH.
- FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Dispatch on opcode: 0x23/0x2B → MEM_ADDR; 0x00 → R_EXEC; 0x08/0x0C/0x0D → I_EXEC; 0x04/0x05 → BRANCH; 0x02 → JUMP; any other → HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: mem_read, i_or_d=1 → MEM_WB. MEM_WB: reg_write, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write, i_or_d=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB. R_WB: reg_write, reg_dst=1, mem_to_reg=0 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11 → I_WB. I_WB: reg_write, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01, branch_ne=(opcode==0x05) → FETCH.
- JUMP: pc_write, pc_source=10 → FETCH.
- HALT: illegal_op=1, all other outputs 0; exits only via reset.
- Any output not listed for a state is 0.

## Timing
- State register updates on rising `clk`; outputs are pure decode of current state (plus `opcode` for branch_ne), no extra latency.
- Cycles per instruction with stall low: lw 5, sw 4, R 4, I-type 4, beq/bne 3, j 3; first FETCH one cycle after INIT.
- `stall` high: state holds; pc_write, pc_write_cond, ir_write, reg_write, mem_write forced 0; mem_read, i_or_d and selects retain state values.
- `rst_n` low at any time, including mid-instruction: state → INIT immediately (asynchronous); all outputs 0 and illegal_op cleared while low; release on a clock edge → INIT, then FETCH.
- `opcode` sampled combinationally in DECODE, MEM_ADDR and BRANCH; IR is stable because ir_write is asserted only in FETCH.

## Structure
- Shared package `mips_pkg`: state enum `ctrl_state_t`, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI), `alu_src_b` / `pc_source` / `alu_op` encodings as localparams shared with the datapath.
- Single module: sequential state register plus combinational next-state and output-decode blocks; no sub-module.

## Test plan
- Reset pulse mid-R_EXEC (rst_n low 2 cycles) → outputs all 0 asynchronously; INIT, then FETCH with mem_read=1, alu_src_b=01, pc_write=1.
- opcode 0x23 → FETCH, DECODE, MEM_ADDR (alu_src_b=10), MEM_READ (i_or_d=1), MEM_WB (reg_write=1, mem_to_reg=1), back to FETCH: 5 cycles.
- opcode 0x00 → R_EXEC alu_op=10, alu_src_b=00; R_WB reg_dst=1, reg_write=1; 4 cycles.
- opcode 0x05 → BRANCH with pc_write_cond=1, branch_ne=1, pc_source=01, alu_op=01; FETCH next.
- `stall` high 3 cycles in MEM_WRITE → state held, mem_write=0 during stall, mem_write=1 for exactly one cycle after release.
- opcode 0x3F → HALT, illegal_op=1 held for 10 cycles, pc_write=0; cleared only by rst_n.
